// File: rtl/gate_sweep_pkg.sv
// Shared definitions for the gate_sweep exhaustive gate tester: op encoding,
// op width and FSM state encoding.
package gate_sweep_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NAND = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_BUF  = 3'd6,
    OP_NOT  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_e;

endpackage

// File: rtl/gate_sweep_ref.sv
// Combinational reference gate: the expected output of an N_IN-input gate of
// function op for input vector stim.
module gate_ref
  import gate_sweep_pkg::*;
#(
  parameter int N_IN = 2
) (
  input  logic [N_IN-1:0] stim,
  input  op_e             op,
  output logic            y
);

  // NOTE: every variable driven in always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    y = 1'b0;
    case (op)
      OP_AND:  y = &stim;
      OP_OR:   y = |stim;
      OP_NAND: y = ~&stim;
      OP_NOR:  y = ~|stim;
      OP_XOR:  y = ^stim;
      OP_XNOR: y = ~^stim;
      OP_BUF:  y = stim[0];
      OP_NOT:  y = ~stim[0];
    endcase
  end

endmodule

// File: rtl/gate_sweep.sv
// Exhaustive sweep tester for an external N_IN-input gate. Each vector gets one
// SETTLE cycle and one CHECK cycle. Define GATE_SWEEP_TT_EN to capture the
// observed truth table; otherwise truth_table is tied to zero.
module gate_sweep
  import gate_sweep_pkg::*;
#(
  parameter int N_IN = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [OP_W-1:0]      op,
  output logic [N_IN-1:0]      stim,
  input  logic                 dut_y,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N_IN:0]        err_cnt,
  output logic [N_IN-1:0]      first_fail,
  output logic [(2**N_IN)-1:0] truth_table
);

  state_e      state;
  op_e         op_q;
  logic        ref_y;
  logic        mismatch;
  logic [N_IN:0] err_next;

  gate_ref #(.N_IN(N_IN)) u_ref (
    .stim (stim),
    .op   (op_q),
    .y    (ref_y)
  );

  assign mismatch = (dut_y != ref_y);
  // At most 2**N_IN mismatches, which always fits in N_IN+1 bits.
  assign err_next = err_cnt + (N_IN+1)'(mismatch);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      op_q       <= OP_AND;
      stim       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      first_fail <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q       <= op_e'(op);
            stim       <= '0;
            err_cnt    <= '0;
            first_fail <= '0;
            pass       <= 1'b0;
            busy       <= 1'b1;
            state      <= S_SETTLE;
          end
        end
        S_SETTLE: state <= S_CHECK;
        S_CHECK: begin
          err_cnt <= err_next;
          if (mismatch && err_cnt == '0) first_fail <= stim;
          if (stim == '1) begin
            // done and pass become visible together on entry to DONE.
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
            state <= S_DONE;
          end else begin
            stim  <= stim + N_IN'(1);
            state <= S_SETTLE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef GATE_SWEEP_TT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      truth_table <= '0;
    end else if (state == S_IDLE && start) begin
      truth_table <= '0;
    end else if (state == S_CHECK) begin
      truth_table[stim] <= dut_y;
    end
  end
`else
  assign truth_table = '0;
`endif

endmodule

// File: tb/tb_gate_sweep.sv
// Scoreboard bench for gate_sweep: an N_IN=2 and an N_IN=3 instance, each
// driving a modelled external gate that may be correct, stuck or bit-flipped.
module tb_gate_sweep;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start_a, start_b;
  logic [2:0] op_a, op_b;

  logic [1:0] stim_a;  logic dut_y_a, busy_a, done_a, pass_a;
  logic [2:0] err_a;   logic [1:0] ff_a;  logic [3:0] tt_a;
  logic [2:0] stim_b;  logic dut_y_b, busy_b, done_b, pass_b;
  logic [3:0] err_b;   logic [2:0] ff_b;  logic [7:0] tt_b;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // External gate configuration: gate op, fault mode (0 ok, 1 stuck0,
  // 2 stuck1, 3 flip by mask), flip mask indexed by vector.
  int g_op_a = 0, g_mode_a = 0, g_flip_a = 0;
  int g_op_b = 0, g_mode_b = 0, g_flip_b = 0;

  typedef struct {
    int err;
    int first;
    int pass;
    int tt;
    int done_cyc;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];

  gate_sweep #(.N_IN(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .op(op_a), .stim(stim_a),
    .dut_y(dut_y_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_cnt(err_a), .first_fail(ff_a), .truth_table(tt_a)
  );

  gate_sweep #(.N_IN(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .op(op_b), .stim(stim_b),
    .dut_y(dut_y_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_cnt(err_b), .first_fail(ff_b), .truth_table(tt_b)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Ideal gate function from the op table, as plain arithmetic on the vector.
  function automatic bit gate_fn(input int op, input int v, input int n);
    int all;
    int x;
    all = (1 << n) - 1;
    x = v & all;
    case (op)
      0:       return x == all;
      1:       return x != 0;
      2:       return x != all;
      3:       return x == 0;
      4:       return ($countones(x) % 2) == 1;
      5:       return ($countones(x) % 2) == 0;
      6:       return (x & 1) == 1;
      default: return (x & 1) == 0;
    endcase
  endfunction

  function automatic bit gate_out(input int gop, input int mode, input int flips,
                                  input int v, input int n);
    case (mode)
      1:       return 1'b0;
      2:       return 1'b1;
      3:       return gate_fn(gop, v, n) ^ bit'((flips >> v) & 1);
      default: return gate_fn(gop, v, n);
    endcase
  endfunction

  always_comb dut_y_a = gate_out(g_op_a, g_mode_a, g_flip_a, int'(stim_a), 2);
  always_comb dut_y_b = gate_out(g_op_b, g_mode_b, g_flip_b, int'(stim_b), 3);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitors: pop the expected result whenever a sweep completes.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done_a) begin
      check("a_sb_nonempty", sb_a.size() > 0, 1);
      if (sb_a.size() > 0) begin
        e = sb_a.pop_front();
        check("a_done_cycle", cyc, e.done_cyc);
        check("a_err_cnt", err_a, e.err);
        check("a_pass", pass_a, e.pass);
        check("a_truth_table", tt_a, e.tt);
        check("a_busy_in_done", busy_a, 0);
        if (e.err != 0) check("a_first_fail", ff_a, e.first);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done_b) begin
      check("b_sb_nonempty", sb_b.size() > 0, 1);
      if (sb_b.size() > 0) begin
        e = sb_b.pop_front();
        check("b_done_cycle", cyc, e.done_cyc);
        check("b_err_cnt", err_b, e.err);
        check("b_pass", pass_b, e.pass);
        check("b_truth_table", tt_b, e.tt);
        check("b_busy_in_done", busy_b, 0);
        if (e.err != 0) check("b_first_fail", ff_b, e.first);
      end
    end
  end

  task automatic wait_idle(input int which);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (which == 0 ? (!busy_a && !done_a) : (!busy_b && !done_b)) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_idle_in_budget", ok, 1);
  endtask

  task automatic wait_done(input int which);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (which == 0 ? done_a : done_b) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_done_in_budget", ok, 1);
  endtask

  // Issue one sweep: work out the whole expected outcome up front, then pulse start.
  task automatic issue(input int which, input int op, input int gop,
                       input int mode, input int flips);
    int n, nv, err, first, tt;
    bit r, a;
    exp_t e;
    n = (which == 0) ? 2 : 3;
    nv = 1 << n;
    err = 0; first = 0; tt = 0;
    for (int v = 0; v < nv; v++) begin
      r = gate_fn(op, v, n);
      a = gate_out(gop, mode, flips, v, n);
      if (r != a) begin
        if (err == 0) first = v;
        err++;
      end
      if (a) tt |= (1 << v);
    end
    e.err = err;
    e.first = first;
    e.pass = (err == 0) ? 1 : 0;
`ifdef GATE_SWEEP_TT_EN
    e.tt = tt;
`else
    e.tt = 0;
`endif
    wait_idle(which);
    if (which == 0) begin
      g_op_a = gop; g_mode_a = mode; g_flip_a = flips;
      op_a = 3'(op); start_a = 1'b1;
    end else begin
      g_op_b = gop; g_mode_b = mode; g_flip_b = flips;
      op_b = 3'(op); start_b = 1'b1;
    end
    e.done_cyc = cyc + 1 + 2 * nv;
    if (which == 0) sb_a.push_back(e); else sb_b.push_back(e);
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int op0, mode, gop;
    rst_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0;
    op_a = '0; op_b = '0;
    repeat (2) @(negedge clk);

    check("rst_stim_a", stim_a, 0);
    check("rst_busy_a", busy_a, 0);
    check("rst_done_a", done_a, 0);
    check("rst_pass_a", pass_a, 0);
    check("rst_err_a", err_a, 0);
    check("rst_ff_a", ff_a, 0);
    check("rst_tt_a", tt_a, 0);
    check("rst_busy_b", busy_b, 0);
    rst_n = 1'b1;

    // AND with a correct gate.
    issue(0, 0, 0, 0, 0);
    wait_done(0);
    check("and_pass", pass_a, 1);
    check("and_err", err_a, 0);
`ifdef GATE_SWEEP_TT_EN
    check("and_tt", tt_a, 4'b1000);
`else
    check("and_tt", tt_a, 0);
`endif

    // OR against a gate stuck at 0.
    issue(0, 1, 1, 1, 0);
    wait_done(0);
    check("or_stuck_err", err_a, 3);
    check("or_stuck_first", ff_a, 2'b01);
    check("or_stuck_pass", pass_a, 0);

    // 3-input XOR with a correct gate.
    issue(1, 4, 4, 0, 0);
    wait_done(1);
    check("xor3_pass", pass_b, 1);
`ifdef GATE_SWEEP_TT_EN
    check("xor3_tt", tt_b, 8'b10010110);
`else
    check("xor3_tt", tt_b, 0);
`endif

    // NAND with a correct gate; then a start during the DONE cycle is ignored.
    issue(0, 2, 2, 0, 0);
    wait_done(0);
    check("nand_pass", pass_a, 1);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("start_in_done_ignored", busy_a, 0);
    @(negedge clk);
    check("still_idle_busy", busy_a, 0);
    check("still_idle_done", done_a, 0);
    check("pass_held", pass_a, 1);

    // Reset during the third CHECK cycle, then a fresh sweep.
    issue(0, 5, 5, 0, 0);
    repeat (5) @(negedge clk);
    check("third_check_stim", stim_a, 2);
    check("third_check_busy", busy_a, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_stim", stim_a, 0);
    check("midrst_busy", busy_a, 0);
    check("midrst_done", done_a, 0);
    check("midrst_pass", pass_a, 0);
    check("midrst_err", err_a, 0);
    check("midrst_ff", ff_a, 0);
    check("midrst_tt", tt_a, 0);
    void'(sb_a.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    issue(0, 3, 3, 0, 0);
    wait_done(0);

    // start and op toggled while busy: no restart, original op retained.
    op0 = int'($urandom_range(0, 7));
    issue(1, op0, op0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      op_b = 3'((op0 + 1 + int'($urandom_range(0, 6))) % 8);
      start_b = 1'b1;
      @(negedge clk);
    end
    start_b = 1'b0;
    wait_done(1);
    check("busy_restart_pass", pass_b, 1);

    // Randomised sweeps on both widths.
    for (int t = 0; t < 30; t++) begin
      int which, op;
      which = int'($urandom_range(0, 1));
      op = int'($urandom_range(0, 7));
      mode = int'($urandom_range(0, 4));
      gop = op;
      if (mode == 4) begin
        gop = int'($urandom_range(0, 7));
        mode = 0;
      end
      issue(which, op, gop, mode, int'($urandom_range(0, 255)));
      wait_done(which);
    end

    repeat (3) @(negedge clk);
    check("sb_a_drained", sb_a.size(), 0);
    check("sb_b_drained", sb_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gate_sweep.md
GATE_SWEEP -- requirements
Module: gate_sweep

Interface
REQ-001 SHALL have parameter N_IN, default 2, meaning gate input count (legal 2..8).
REQ-002 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, meaning request to begin an exhaustive sweep; sampled only in IDLE.
REQ-005 SHALL have port op, input, 3, meaning gate function: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 BUF(stim[0]), 7 NOT(stim[0]).
REQ-006 SHALL have port stim, output, N_IN, meaning the registered input vector driven to the external gate under test.
REQ-007 SHALL have port dut_y, input, 1, meaning the output of the external gate under test.
REQ-008 SHALL have port busy, output, 1, meaning a sweep is in progress.
REQ-009 SHALL have port done, output, 1, meaning a one-cycle pulse at sweep completion.
REQ-010 SHALL have port pass, output, 1, meaning the last sweep had zero mismatches; held until the next start.
REQ-011 SHALL have port err_cnt, output, N_IN+1, meaning the mismatch count for the current or last sweep.
REQ-012 SHALL have port first_fail, output, N_IN, meaning the stim value of the first mismatch; meaningful only when err_cnt is nonzero.
REQ-013 SHALL have port truth_table, output, 2**N_IN, meaning dut_y as captured per vector, with bit i holding the result for stim equal to i.

Function
REQ-014 SHALL implement an FSM with states IDLE, SETTLE, CHECK and DONE.
REQ-015 SHALL, in IDLE with start high, latch op, clear stim, err_cnt, first_fail and truth_table, clear pass, and enter SETTLE.
REQ-016 SHALL hold stim stable in SETTLE for exactly one cycle, then enter CHECK.
REQ-017 SHALL, in CHECK, compare dut_y against the reference function of stim under the latched op, increment err_cnt on mismatch, and record first_fail only on the first mismatch.
REQ-018 SHALL, in CHECK with stim not all-ones, increment stim and return to SETTLE; with stim all-ones, SHALL enter DONE.
REQ-019 SHALL, in DONE, assert done for one cycle, set pass high if and only if err_cnt is 0, and return to IDLE.
REQ-020 SHALL enter DONE exactly 2*2**N_IN cycles after the start-sampling edge (8 cycles for N_IN=2).
REQ-021 SHALL assert busy in SETTLE and CHECK only.
REQ-022 SHALL ignore start outside IDLE and SHALL ignore op changes during a sweep.
REQ-023 SHALL not let err_cnt overflow, since its maximum value is 2**N_IN.
REQ-024 SHALL treat a start asserted in the DONE cycle as ignored, and SHALL sample it again in IDLE.

Reset
REQ-025 SHALL, on rst_n low including mid-sweep, set the state to IDLE and set stim, busy, done, pass, err_cnt, first_fail and truth_table to 0.

Configuration
REQ-026 SHALL, with GATE_SWEEP_TT_EN defined, capture dut_y into truth_table[stim] in each CHECK cycle.
REQ-027 SHALL, without GATE_SWEEP_TT_EN, keep the truth_table port and tie it to constant 0, with no capture register synthesised.

Structure
REQ-028 SHALL place the op encoding enum, the op width constant and the FSM state encoding in package gate_sweep_pkg.
REQ-029 SHALL compute the expected value in combinational sub-module gate_ref, with parameter N_IN and inputs stim and op, so that the reduction-gate logic is reusable.

Verification
REQ-030 SHALL cover: N_IN=2, op=0, dut_y tied to the AND of stim -> done 8 cycles after start, pass=1, err_cnt=0, truth_table=4'b1000 with the macro defined.
REQ-031 SHALL cover: N_IN=2, op=1, dut_y stuck at 0 -> err_cnt=3, first_fail=2'b01, pass=0.
REQ-032 SHALL cover: N_IN=3, op=4, dut_y tied to the XOR of stim -> done 16 cycles after start, pass=1, truth_table=8'b10010110.
REQ-033 SHALL cover: rst_n pulsed low during the third CHECK -> all outputs 0 immediately, and a fresh start then completes a normal 8-cycle sweep.
REQ-034 SHALL cover: start re-asserted and op changed while busy -> no restart, and the result reflects the originally latched op.
REQ-035 SHALL cover: macro undefined, N_IN=2, op=2 with a correct NAND -> pass=1 and truth_table=0.
